unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/unified_mem_arbiter_if.sv | 42 ++++
 rtl/mem_arb_pick.sv | 19 +
 rtl/unified_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified fetch/data memory arbiter: FSM encoding,
// access size codes, grant vector indices and the default starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int GNT_IF = 0;
    localparam int GNT_DM = 1;

    localparam int STARVE_LIMIT_DEFAULT = 3;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side and memory-side signal bundle of the arbiter.
// Handshake: x_req is held by the requester until its one-cycle x_done pulse; mem_req and all mem_* fields stay stable until the cycle mem_ack is high.
interface unified_mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        input  mem_ack, mem_rdata,
        output if_done, if_rdata, dm_done, dm_rdata,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        output mem_ack, mem_rdata,
        input  if_done, if_rdata, dm_done, dm_rdata,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata, stall
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data stage wins unless fetch is being forced.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_dm_req,
    input  logic       i_fetch_forced,
    output logic [1:0] o_grant
);

    logic w_dm_win;

    // Forcing only matters while fetch is actually waiting, so a lone
    // data request is never blocked by a saturated streak.
    assign w_dm_win        = i_dm_req & ~(i_fetch_forced & i_if_req);
    assign o_grant[GNT_DM] = w_dm_win;
    assign o_grant[GNT_IF] = i_if_req & ~w_dm_win;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data-stage accesses onto one single-port memory.
// Optional ARB_STARVE_GUARD_EN: limits consecutive data grants while fetch waits.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    unified_mem_arbiter_if.slave  io_bus,
    output state_t                o_state
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_if_done;
    logic        r_dm_done;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [1:0]  r_mem_size;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        w_idle_free;
    logic        w_fetch_forced;
    logic        w_ack_if;
    logic        w_ack_dm;
    logic [1:0]  w_pick;
    logic [1:0]  w_grant;

    // No grant in the cycle a done pulses: the requester still holds req then.
    assign w_idle_free = (r_state == ST_IDLE) & ~r_if_done & ~r_dm_done;
    assign w_grant     = w_pick & {2{w_idle_free}};
    assign w_ack_if    = (r_state == ST_BUSY_IF) & io_bus.mem_ack;
    assign w_ack_dm    = (r_state == ST_BUSY_DM) & io_bus.mem_ack;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    logic [STREAK_W-1:0] r_dm_streak;

    assign w_fetch_forced = (r_dm_streak == STREAK_W'(STARVE_LIMIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dm_streak <= '0;
        end else if (w_grant[GNT_IF]) begin
            r_dm_streak <= '0;
        end else if (w_grant[GNT_DM] && io_bus.if_req && !w_fetch_forced) begin
            r_dm_streak <= r_dm_streak + 1'b1;
        end
    end
`else
    assign w_fetch_forced = 1'b0;
`endif

    mem_arb_pick u_pick (
        .i_if_req       (io_bus.if_req),
        .i_dm_req       (io_bus.dm_req),
        .i_fetch_forced (w_fetch_forced),
        .o_grant        (w_pick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant[GNT_DM]) begin
                    w_state_nxt = ST_BUSY_DM;
                end else if (w_grant[GNT_IF]) begin
                    w_state_nxt = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                if (io_bus.mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_done <= w_ack_if;
            r_dm_done <= w_ack_dm;
            if (w_grant[GNT_DM]) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= io_bus.dm_we;
                r_mem_size  <= io_bus.dm_size;
                r_mem_addr  <= io_bus.dm_addr;
                r_mem_wdata <= io_bus.dm_wdata;
            end else if (w_grant[GNT_IF]) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_size  <= SIZE_WORD;
                r_mem_addr  <= io_bus.if_addr;
            end else if (w_ack_if || w_ack_dm) begin
                r_mem_req   <= 1'b0;
            end
            if (w_ack_if) begin
                r_if_rdata <= io_bus.mem_rdata;
            end
            if (w_ack_dm) begin
                r_dm_rdata <= io_bus.mem_rdata;
            end
        end
    end

    assign io_bus.if_done   = r_if_done;
    assign io_bus.dm_done   = r_dm_done;
    assign io_bus.if_rdata  = r_if_rdata;
    assign io_bus.dm_rdata  = r_dm_rdata;
    assign io_bus.mem_req   = r_mem_req;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_size  = r_mem_size;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.stall     = (io_bus.if_req & ~r_if_done) | (io_bus.dm_req & ~r_dm_done);
    assign o_state          = r_state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios then randomized rounds,
// checked against a transaction-level arbitration and memory model.
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LIMIT = 3;

  typedef struct packed {
    logic        is_dm;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic   clk;
  logic   rst_n;
  state_t dut_state;
  unified_mem_arbiter_if bus();

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int          streak = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;
  bit          dm_known = 1'b1;
  logic [31:0] ref_mem [logic [31:0]];

  // memory environment
  logic [31:0] env_mem [logic [31:0]];
  int          cur_wait = 0;
  bit          mem_hold = 1'b0;
  bit          inject_ack = 1'b0;
  int          busy_cnt = 0;

  unified_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus),
    .o_state (dut_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_val(a);
  endfunction

  function automatic bit fetch_forced();
`ifdef ARB_STARVE_GUARD_EN
    return streak == LIMIT;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory responder: acks after cur_wait extra cycles, applies stores
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        busy_cnt    = 0;
      end else if (inject_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5A5A_0001;
        inject_ack    = 1'b0;
      end else if (bus.mem_req && !mem_hold) begin
        if (busy_cnt >= cur_wait) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            env_mem[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = '0;
          end else begin
            bus.mem_rdata = env_rd(bus.mem_addr);
          end
          busy_cnt = 0;
        end else begin
          busy_cnt++;
        end
      end
    end
  end

  // driver + scoreboard for one round of up to two requests raised together
  task automatic run_round(input string tag, input bit do_if, input bit do_dm,
                           input logic [31:0] ia, input logic dwe, input logic [1:0] dsz,
                           input logic [31:0] da, input logic [31:0] dwd,
                           input int wt, input bit drop_dm);
    txn_t exp_q[$];
    txn_t ti, td, cur;
    bit   active = 1'b0;
    bit   rose;
    bit   exp_busy, exp_ifd, exp_dmd;
    int   t = 0, exp_rise = 1, done_t = 0, finish_t = 0;
    ti = '0; ti.is_dm = 1'b0; ti.we = 1'b0; ti.sz = SIZE_WORD; ti.addr = ia;
    td = '0; td.is_dm = 1'b1; td.we = dwe; td.sz = dsz; td.addr = da; td.wdata = dwd;
    if (do_dm && !(do_if && fetch_forced())) begin
      exp_q.push_back(td);
      if (do_if) exp_q.push_back(ti);
    end else begin
      if (do_if) exp_q.push_back(ti);
      if (do_dm) exp_q.push_back(td);
    end
    cur = '0;
    cur_wait = wt;
    bus.if_addr = ia; bus.dm_we = dwe; bus.dm_size = dsz; bus.dm_addr = da; bus.dm_wdata = dwd;
    bus.if_req = do_if;
    bus.dm_req = do_dm;
    while (t < 80) begin
      @(negedge clk);
      t++;
      rose = 1'b0;
      if (!active && exp_q.size() > 0 && t == exp_rise) begin
        cur    = exp_q.pop_front();
        active = 1'b1;
        rose   = 1'b1;
        done_t = t + wt + 1;
        if (cur.is_dm) begin
          if (bus.if_req) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
          if (cur.we) ref_mem[cur.addr] = cur.wdata;
          else        cur.rdata = ref_rd(cur.addr);
        end else begin
          streak = 0;
          cur.rdata = ref_rd(cur.addr);
        end
      end
      exp_busy = active && (t < done_t);
      exp_ifd  = active && !cur.is_dm && (t == done_t);
      exp_dmd  = active && cur.is_dm && (t == done_t);
      check({tag, "/mem_req"}, bus.mem_req, exp_busy);
      check({tag, "/if_done"}, bus.if_done, exp_ifd);
      check({tag, "/dm_done"}, bus.dm_done, exp_dmd);
      check({tag, "/stall"}, bus.stall, (bus.if_req & ~exp_ifd) | (bus.dm_req & ~exp_dmd));
      check({tag, "/state"}, 32'(dut_state),
            32'(exp_busy ? (cur.is_dm ? ST_BUSY_DM : ST_BUSY_IF) : ST_IDLE));
      if (exp_busy) begin
        check({tag, "/mem_we"}, bus.mem_we, cur.we);
        check({tag, "/mem_size"}, bus.mem_size, cur.sz);
        check({tag, "/mem_addr"}, bus.mem_addr, cur.addr);
        if (cur.is_dm) check({tag, "/mem_wdata"}, bus.mem_wdata, cur.wdata);
      end
      if (exp_ifd) begin
        check({tag, "/if_rdata"}, bus.if_rdata, cur.rdata);
        if (dm_known) check({tag, "/dm_rdata_hold"}, bus.dm_rdata, last_dm);
        last_if = cur.rdata;
      end
      if (exp_dmd) begin
        if (!cur.we) check({tag, "/dm_rdata"}, bus.dm_rdata, cur.rdata);
        check({tag, "/if_rdata_hold"}, bus.if_rdata, last_if);
        dm_known = !cur.we;
        if (!cur.we) last_dm = cur.rdata;
      end
      if (active && t == done_t) begin
        if (cur.is_dm) bus.dm_req = 1'b0;
        else           bus.if_req = 1'b0;
        active   = 1'b0;
        exp_rise = t + 2;
        if (exp_q.size() == 0) finish_t = t + 1;
      end
      if (rose && cur.is_dm && drop_dm) bus.dm_req = 1'b0;
      if (exp_q.size() == 0 && !active && finish_t > 0 && t >= finish_t) break;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  initial begin
    int   grants, dones, cyc;
    bit   prev_req, exp_dm;
    rst_n        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_size  = '0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst/state", 32'(dut_state), 32'(ST_IDLE));
    check("rst/mem_req", bus.mem_req, 1'b0);
    check("rst/mem_we", bus.mem_we, 1'b0);
    check("rst/mem_addr", bus.mem_addr, 32'h0);
    check("rst/mem_wdata", bus.mem_wdata, 32'h0);
    check("rst/if_done", bus.if_done, 1'b0);
    check("rst/dm_done", bus.dm_done, 1'b0);
    check("rst/if_rdata", bus.if_rdata, 32'h0);
    check("rst/dm_rdata", bus.dm_rdata, 32'h0);
    check("rst/stall", bus.stall, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed scenarios
    run_round("fetch40", 1, 0, 32'h40, 1'b0, SIZE_WORD, 32'h0, 32'h0, 0, 0);
    check("fetch40/rdata_const", bus.if_rdata, 32'h8C22_0004);
    @(negedge clk);
    run_round("both_store", 1, 1, 32'h44, 1'b1, SIZE_WORD, 32'h100, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    run_round("wait5", 0, 1, 32'h0, 1'b1, SIZE_HALF, 32'h104, 32'hCAFE_0001, 5, 0);
    @(negedge clk);
    run_round("wait5_load", 0, 1, 32'h0, 1'b0, SIZE_WORD, 32'h104, 32'h0, 5, 0);
    check("wait5_load/const", bus.dm_rdata, 32'hCAFE_0001);
    @(negedge clk);
    run_round("drop_dm", 1, 1, 32'h48, 1'b0, SIZE_BYTE, 32'h100, 32'h0, 2, 1);
    check("drop_dm/const", bus.dm_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // reset in the middle of a data access, then a stray ack
    mem_hold = 1'b1;
    bus.dm_we = 1'b1; bus.dm_size = SIZE_WORD; bus.dm_addr = 32'h1F0; bus.dm_wdata = 32'h1234_5678;
    bus.dm_req = 1'b1;
    @(negedge clk);
    check("rstmid/mem_req", bus.mem_req, 1'b1);
    check("rstmid/state", 32'(dut_state), 32'(ST_BUSY_DM));
    check("rstmid/mem_addr", bus.mem_addr, 32'h1F0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstasync/mem_req", bus.mem_req, 1'b0);
    check("rstasync/mem_we", bus.mem_we, 1'b0);
    check("rstasync/mem_addr", bus.mem_addr, 32'h0);
    check("rstasync/mem_wdata", bus.mem_wdata, 32'h0);
    check("rstasync/state", 32'(dut_state), 32'(ST_IDLE));
    check("rstasync/if_rdata", bus.if_rdata, 32'h0);
    check("rstasync/dm_rdata", bus.dm_rdata, 32'h0);
    bus.dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    inject_ack = 1'b1;
    streak = 0; last_if = '0; last_dm = '0; dm_known = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lateack/dm_done", bus.dm_done, 1'b0);
      check("lateack/mem_req", bus.mem_req, 1'b0);
      check("lateack/state", 32'(dut_state), 32'(ST_IDLE));
    end

    // both requests held continuously: grant order from the starvation rule
    cur_wait = 0;
    bus.if_addr = 32'h40;
    bus.dm_we = 1'b0; bus.dm_size = SIZE_WORD; bus.dm_addr = 32'h104;
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    grants = 0; dones = 0; cyc = 0; prev_req = 1'b0;
    while (dones < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req && !prev_req) begin
        exp_dm = !fetch_forced();
        if (exp_dm) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
        else        streak = 0;
        check($sformatf("stream/grant%0d", grants), 32'(dut_state),
              32'(exp_dm ? ST_BUSY_DM : ST_BUSY_IF));
        grants++;
      end
      if (bus.dm_done) begin
        check("stream/dm_rdata", bus.dm_rdata, ref_rd(32'h104));
        last_dm = ref_rd(32'h104);
        dones++;
      end
      if (bus.if_done) begin
        check("stream/if_rdata", bus.if_rdata, ref_rd(32'h40));
        last_if = ref_rd(32'h40);
        dones++;
      end
      prev_req = bus.mem_req;
    end
    check("stream/grants", grants, 8);
    check("stream/dones", dones, 8);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      bit di, dd;
      di = 1'($urandom_range(0, 1));
      dd = 1'($urandom_range(0, 1));
      if (!di && !dd) dd = 1'b1;
      run_round($sformatf("rand%0d", r), di, dd,
                32'h100 + 32'($urandom_range(0, 15) << 2),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                32'h100 + 32'($urandom_range(0, 15) << 2), $urandom,
                int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
